// File: rtl/bg_pkg.sv
// Shared types and constants for the background pixel fetch path.
package bg_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb24_t;

    localparam int TILE_W_DEF = 20;
    localparam int TILE_H_DEF = 20;
    localparam int SCALE_DEF  = 4;

    // Sky blue, two grass greens, three dirt browns, black, white.
    localparam rgb24_t PALETTE [0:7] = '{
        '{r: 8'h87, g: 8'hCE, b: 8'hEB},
        '{r: 8'h22, g: 8'h8B, b: 8'h22},
        '{r: 8'h00, g: 8'h64, b: 8'h00},
        '{r: 8'h8B, g: 8'h45, b: 8'h13},
        '{r: 8'hA0, g: 8'h52, b: 8'h2D},
        '{r: 8'h5C, g: 8'h40, b: 8'h33},
        '{r: 8'h00, g: 8'h00, b: 8'h00},
        '{r: 8'hFF, g: 8'hFF, b: 8'hFF}
    };

endpackage

// File: rtl/bg_palette.sv
// Registered palette lookup (pipeline stage 3) with a sticky bad-index flag.
module bg_palette
    import bg_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       valid,
    input  logic [4:0] index,
    output rgb24_t     rgb,
    output logic       err
);

    // Map index to colour; black when not valid or index out of range.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb <= '0;
            err <= 1'b0;
        end else begin
            if (valid && index[4:3] == 2'b00) begin
                rgb <= PALETTE[index[2:0]];
            end else begin
                rgb <= '0;
            end
            if (valid && index[4:3] != 2'b00) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/bg_pixel_fetch.sv
// Background tile fetch: scan counters -> frame RAM address -> palette RGB,
// with valid/sync strobes delayed to line up with the RGB output.
module bg_pixel_fetch
    import bg_pkg::*;
#(
    parameter int TILE_W = TILE_W_DEF,
    parameter int TILE_H = TILE_H_DEF,
    parameter int SCALE  = SCALE_DEF,
    parameter int ADDR_W = 19
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_start,
    input  logic              line_start,
    input  logic              pixel_valid,
    input  logic              hs_in,
    input  logic              vs_in,
    output logic [ADDR_W-1:0] read_address,
    input  logic [4:0]        ram_data,
    output logic [7:0]        rgb_r,
    output logic [7:0]        rgb_g,
    output logic [7:0]        rgb_b,
    output logic              rgb_valid,
    output logic              hs_out,
    output logic              vs_out,
    output logic              palette_err
);

    localparam int SUB_W = (SCALE  > 1) ? $clog2(SCALE)  : 1;
    localparam int XT_W  = (TILE_W > 1) ? $clog2(TILE_W) : 1;
    localparam int YT_W  = (TILE_H > 1) ? $clog2(TILE_H) : 1;

    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SCALE - 1);
    localparam logic [XT_W-1:0]  XT_LAST  = XT_W'(TILE_W - 1);
    localparam logic [YT_W-1:0]  YT_LAST  = YT_W'(TILE_H - 1);

    logic [SUB_W-1:0]  x_sub;
    logic [XT_W-1:0]   x_tile;
    logic [SUB_W-1:0]  y_sub;
    logic [YT_W-1:0]   y_tile;
    logic [ADDR_W-1:0] row_base;

    logic [2:0] valid_sr;
    logic [2:0] hs_sr;
    logic [2:0] vs_sr;

    rgb24_t pix;

    // Horizontal position: cleared by line_start, advanced per active pixel.
    always_ff @(posedge Clk) begin
        if (Reset || line_start) begin
            x_sub  <= '0;
            x_tile <= '0;
        end else if (pixel_valid) begin
            if (x_sub == SUB_LAST) begin
                x_sub  <= '0;
                x_tile <= (x_tile == XT_LAST) ? '0 : x_tile + 1'b1;
            end else begin
                x_sub <= x_sub + 1'b1;
            end
        end
    end

    // Vertical position and row_base (= y_tile*TILE_W) kept in lockstep,
    // so no multiplier is needed.
    always_ff @(posedge Clk) begin
        if (Reset || frame_start) begin
            y_sub    <= '0;
            y_tile   <= '0;
            row_base <= '0;
        end else if (line_start) begin
            if (y_sub == SUB_LAST) begin
                y_sub <= '0;
                if (y_tile == YT_LAST) begin
                    y_tile   <= '0;
                    row_base <= '0;
                end else begin
                    y_tile   <= y_tile + 1'b1;
                    row_base <= row_base + ADDR_W'(TILE_W);
                end
            end else begin
                y_sub <= y_sub + 1'b1;
            end
        end
    end

    // Stage 1: address register, built from pre-update counter values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            read_address <= '0;
        end else if (pixel_valid) begin
            read_address <= row_base + ADDR_W'(x_tile);
        end
    end

    // Strobe delay lines matching the 3-cycle address/RAM/palette path.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid_sr <= '0;
            hs_sr    <= '1;
            vs_sr    <= '1;
        end else begin
            valid_sr <= {valid_sr[1:0], pixel_valid};
            hs_sr    <= {hs_sr[1:0], hs_in};
            vs_sr    <= {vs_sr[1:0], vs_in};
        end
    end

    bg_palette u_palette (
        .clk   (Clk),
        .reset (Reset),
        .valid (valid_sr[1]),
        .index (ram_data),
        .rgb   (pix),
        .err   (palette_err)
    );

    assign rgb_r     = pix.r;
    assign rgb_g     = pix.g;
    assign rgb_b     = pix.b;
    assign rgb_valid = valid_sr[2];
    assign hs_out    = hs_sr[2];
    assign vs_out    = vs_sr[2];

endmodule

// File: tb/tb_bg_pixel_fetch.sv
// Scoreboard bench for bg_pixel_fetch with a stub frame RAM and a
// position-based reference model (line/column counts -> tile address).
module tb_bg_pixel_fetch;
    import bg_pkg::*;

    localparam int TW = 20;
    localparam int TH = 20;
    localparam int SC = 4;
    localparam int AW = 19;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          frame_start = 1'b0;
    logic          line_start = 1'b0;
    logic          pixel_valid = 1'b0;
    logic          hs_in = 1'b1;
    logic          vs_in = 1'b1;
    logic [AW-1:0] read_address;
    logic [4:0]    ram_data;
    logic [7:0]    rgb_r, rgb_g, rgb_b;
    logic          rgb_valid, hs_out, vs_out, palette_err;

    always #5 Clk = ~Clk;

    bg_pixel_fetch #(.TILE_W(TW), .TILE_H(TH), .SCALE(SC), .ADDR_W(AW)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_start  (frame_start),
        .line_start   (line_start),
        .pixel_valid  (pixel_valid),
        .hs_in        (hs_in),
        .vs_in        (vs_in),
        .read_address (read_address),
        .ram_data     (ram_data),
        .rgb_r        (rgb_r),
        .rgb_g        (rgb_g),
        .rgb_b        (rgb_b),
        .rgb_valid    (rgb_valid),
        .hs_out       (hs_out),
        .vs_out       (vs_out),
        .palette_err  (palette_err)
    );

    // Stub frame RAM with one-cycle synchronous read.
    logic [4:0] mem [0:TW*TH-1];
    always @(posedge Clk)
        ram_data <= (read_address < AW'(TW*TH)) ? mem[read_address] : 5'd0;

    int unsigned cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned due;
        logic        v;
        logic [23:0] rgb;
        logic        bad;
        logic        hs;
        logic        vs;
    } sexp_t;
    typedef struct {
        int unsigned due;
        logic [AW-1:0] addr;
    } aexp_t;

    sexp_t sq[$];
    aexp_t aq[$];

    int          tests = 0;
    int          fails = 0;
    int unsigned mon_start = 32'hFFFF_FFFF;
    int unsigned reset_cyc = 32'hFFFF_FFF0;
    logic        exp_err = 1'b0;

    // Reference model state: lines since frame_start, pixels since line_start.
    int            ln = 0;
    int            col = 0;
    logic [AW-1:0] last_addr = '0;

    function automatic logic [23:0] pal_of(logic [4:0] idx);
        logic [23:0] c;
        if (idx < 5'd8) c = PALETTE[idx[2:0]];
        else c = 24'h0;
        return c;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops expectations as they come due and compares DUT outputs.
    always @(negedge Clk) begin
        if (cyc >= mon_start) begin
            if (cyc == reset_cyc + 1) exp_err = 1'b0;
            while (sq.size() > 0 && sq[0].due < cyc) begin
                tests++; fails++;
                $display("FAIL stale_pixel cyc=%0d due=%0d", cyc, sq[0].due);
                void'(sq.pop_front());
            end
            if (sq.size() > 0 && sq[0].due == cyc) begin
                sexp_t e;
                e = sq.pop_front();
                if (e.v && e.bad) exp_err = 1'b1;
                check("rgb_valid", {31'd0, rgb_valid}, {31'd0, e.v});
                check("rgb", {8'd0, rgb_r, rgb_g, rgb_b}, {8'd0, e.rgb});
                check("hs_out", {31'd0, hs_out}, {31'd0, e.hs});
                check("vs_out", {31'd0, vs_out}, {31'd0, e.vs});
            end
            if (aq.size() > 0 && aq[0].due == cyc) begin
                aexp_t a;
                a = aq.pop_front();
                check("read_address", 32'(read_address), 32'(a.addr));
            end
            check("palette_err", {31'd0, palette_err}, {31'd0, exp_err});
        end
    end

    // One stimulus cycle: drive inputs and push the expected responses.
    task automatic step(input logic fs, input logic ls, input logic pv);
        sexp_t e;
        aexp_t a;
        logic [4:0] idx;
        int unsigned n;
        @(posedge Clk); #1;
        n = cyc;
        Reset = 1'b0;
        frame_start = fs;
        line_start = ls;
        pixel_valid = pv;
        hs_in = 1'($urandom_range(0, 1));
        vs_in = 1'($urandom_range(0, 1));
        if (fs) ln = 0;
        else if (ls) ln++;
        if (ls) col = 0;
        if (pv) begin
            last_addr = AW'(((ln / SC) % TH) * TW + ((col / SC) % TW));
            col++;
        end
        idx = pv ? mem[last_addr] : 5'd0;
        e.due = n + 3; e.v = pv; e.rgb = pv ? pal_of(idx) : 24'h0;
        e.bad = pv && (idx >= 5'd8); e.hs = hs_in; e.vs = vs_in;
        sq.push_back(e);
        a.due = n + 1; a.addr = last_addr;
        aq.push_back(a);
    endtask

    task automatic do_reset();
        sexp_t e;
        aexp_t a;
        int unsigned n;
        @(posedge Clk); #1;
        n = cyc;
        Reset = 1'b1;
        frame_start = 1'b0; line_start = 1'b0; pixel_valid = 1'b0;
        hs_in = 1'b1; vs_in = 1'b1;
        while (sq.size() > 0 && sq[sq.size()-1].due > n) void'(sq.pop_back());
        while (aq.size() > 0 && aq[aq.size()-1].due > n) void'(aq.pop_back());
        for (int unsigned k = 1; k <= 3; k++) begin
            e.due = n + k; e.v = 1'b0; e.rgb = 24'h0; e.bad = 1'b0;
            e.hs = 1'b1; e.vs = 1'b1;
            sq.push_back(e);
        end
        a.due = n + 1; a.addr = '0;
        aq.push_back(a);
        ln = 0; col = 0; last_addr = '0;
        reset_cyc = n;
        if (mon_start == 32'hFFFF_FFFF) mon_start = n + 1;
    endtask

    task automatic pixels(input int cnt);
        for (int i = 0; i < cnt; i++) step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic idle(input int cnt);
        for (int i = 0; i < cnt; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int len;
        for (int i = 0; i < TW*TH; i++) mem[i] = 5'($urandom_range(0, 7));
        mem[0] = 5'd2;
        mem[1] = 5'd5;
        repeat (2) @(posedge Clk);
        do_reset();
        idle(6);

        // First pixels of a frame: addresses 0,0,0,0,1,1,1,1; colours 2 then 5.
        step(1'b1, 1'b1, 1'b0);
        pixels(8);
        idle(4);

        // Reset mid-line after 10 pixels.
        step(1'b0, 1'b1, 1'b0);
        pixels(10);
        do_reset();
        idle(5);

        // Full 640-pixel line: horizontal tile wrap every 80 pixels.
        step(1'b1, 1'b1, 1'b0);
        pixels(640);
        idle(5);

        // Random frame: 90 lines, random lengths and gaps, vertical wrap at
        // line 80, and a frame_start mid-frame at line 85.
        for (int l = 0; l < 90; l++) begin
            step((l == 0 || l == 85) ? 1'b1 : 1'b0, 1'b1, 1'b0);
            len = $urandom_range(1, 90);
            for (int p = 0; p < len; p++)
                step(1'b0, 1'b0, ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0);
            idle($urandom_range(2, 6));
        end

        // Out-of-range palette index sets a sticky error; reset clears it.
        mem[3] = 5'b11000;
        step(1'b1, 1'b1, 1'b0);
        pixels(20);
        idle(3);
        step(1'b0, 1'b1, 1'b0);
        pixels(8);
        idle(4);
        do_reset();
        idle(4);
        mem[3] = 5'd4;
        step(1'b1, 1'b1, 1'b0);
        pixels(24);
        idle(6);

        @(negedge Clk); #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
